// File: rtl/acs_survivor_mem_pkg.sv
// Shared constants and helpers for the four-state K=3 (7,5) Viterbi ACS and survivor stage.
package acs_survivor_mem_pkg;

    localparam logic [1:0] S00 = 2'd0;
    localparam logic [1:0] S01 = 2'd1;
    localparam logic [1:0] S10 = 2'd2;
    localparam logic [1:0] S11 = 2'd3;

    localparam logic [2:0] GEN0 = 3'b111;
    localparam logic [2:0] GEN1 = 3'b101;

    localparam int FRAME_LEN = 8;
    localparam int PTR_W     = $clog2(FRAME_LEN);
    localparam int PM_INIT   = 15;

    typedef enum logic [1:0] {
        ST_ACS  = 2'd0,
        ST_LOAD = 2'd1,
        ST_TB   = 2'd2
    } fsm_t;

    // Encoder output {c0, c1} for input u leaving predecessor state p.
    function automatic logic [1:0] expected_sym(input logic u, input logic [1:0] p);
        logic [2:0] shreg;
        shreg = {u, p};
        return {^(shreg & GEN0), ^(shreg & GEN1)};
    endfunction

    function automatic logic [1:0] branch_metric(input logic [1:0] sym, input logic [1:0] exp_sym);
        logic [1:0] d;
        d = sym ^ exp_sym;
        return {d[1] & d[0], d[1] ^ d[0]};
    endfunction

endpackage

// File: rtl/acs_survivor_mem_acs_unit.sv
// One add-compare-select cell: ties resolve to the p[0]=0 predecessor.
module acs_unit #(
    parameter int W = 6
) (
    input  logic [W-1:0] pm0,
    input  logic [W-1:0] pm1,
    input  logic [1:0]   bm0,
    input  logic [1:0]   bm1,
    output logic [W-1:0] pm_new,
    output logic         dec
);

    logic [W-1:0] cand0;
    logic [W-1:0] cand1;

    assign cand0  = pm0 + {{(W-2){1'b0}}, bm0};
    assign cand1  = pm1 + {{(W-2){1'b0}}, bm1};
    assign dec    = (cand1 < cand0);
    assign pm_new = dec ? cand1 : cand0;

endmodule

// File: rtl/acs_survivor_mem.sv
// ACS and survivor memory: accepts one 8-symbol frame, then plays stored predecessors back 7..0.
module acs_survivor_mem
    import acs_survivor_mem_pkg::*;
#(
    parameter int METRIC_W = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    input  logic [1:0] i_symbol,
    output logic       o_ready,
    output logic [1:0] o_select_node,
    output logic       o_en_traceback,
    output logic [1:0] o_bck_prv_st_00,
    output logic [1:0] o_bck_prv_st_01,
    output logic [1:0] o_bck_prv_st_10,
    output logic [1:0] o_bck_prv_st_11
);

    localparam logic [PTR_W-1:0] LAST_STAGE = PTR_W'(FRAME_LEN - 1);
    localparam logic [METRIC_W-1:0] PM_START = METRIC_W'(PM_INIT);

    fsm_t state_reg, state_next;

    logic [METRIC_W-1:0] pm_reg [4];
    logic [METRIC_W-1:0] pm_new [4];
    logic [3:0]          dec_new;
    logic [3:0]          mem [FRAME_LEN];
    logic [3:0]          rd_data_reg;
    logic [PTR_W-1:0]    stage_reg;
    logic [PTR_W-1:0]    ptr_reg;
    logic [PTR_W-1:0]    rd_addr;
    logic [1:0]          sel_reg;
    logic [1:0]          sel_lo, sel_hi, sel_next;
    logic                accept;

    assign accept = i_valid && (state_reg == ST_ACS);

    // State {u, a} is reached from {a,0} and {a,1}.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_acs
            localparam logic [1:0] ST = 2'(gi);
            localparam logic [1:0] P0 = {ST[0], 1'b0};
            localparam logic [1:0] P1 = {ST[0], 1'b1};

            logic [1:0] bm0, bm1;

            assign bm0 = branch_metric(i_symbol, expected_sym(ST[1], P0));
            assign bm1 = branch_metric(i_symbol, expected_sym(ST[1], P1));

            acs_unit #(.W(METRIC_W)) u_acs (
                .pm0    (pm_reg[P0]),
                .pm1    (pm_reg[P1]),
                .bm0    (bm0),
                .bm1    (bm1),
                .pm_new (pm_new[gi]),
                .dec    (dec_new[gi])
            );
        end
    endgenerate

    // Pairwise argmin; lower index wins every tie.
    assign sel_lo   = (pm_new[S01] < pm_new[S00]) ? S01 : S00;
    assign sel_hi   = (pm_new[S11] < pm_new[S10]) ? S11 : S10;
    assign sel_next = (pm_new[sel_hi] < pm_new[sel_lo]) ? sel_hi : sel_lo;

    always_comb begin
        state_next     = state_reg;
        o_ready        = 1'b0;
        o_en_traceback = 1'b0;
        rd_addr        = LAST_STAGE;
        case (state_reg)
            ST_ACS: begin
                o_ready = 1'b1;
                if (accept && stage_reg == LAST_STAGE) state_next = ST_LOAD;
            end
            ST_LOAD: state_next = ST_TB;
            ST_TB: begin
                o_en_traceback = 1'b1;
                // Prefetch the next stage so it is on the outputs one edge later.
                if (ptr_reg != '0) rd_addr = ptr_reg - PTR_W'(1);
                else               state_next = ST_ACS;
            end
            default: state_next = ST_ACS;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_ACS;
            pm_reg[S00] <= '0;
            pm_reg[S01] <= PM_START;
            pm_reg[S10] <= PM_START;
            pm_reg[S11] <= PM_START;
            stage_reg   <= '0;
            ptr_reg     <= LAST_STAGE;
            sel_reg     <= S00;
            rd_data_reg <= '0;
            for (int i = 0; i < FRAME_LEN; i++) mem[i] <= '0;
        end else begin
            state_reg   <= state_next;
            rd_data_reg <= mem[rd_addr];
            if (accept) begin
                for (int i = 0; i < 4; i++) pm_reg[i] <= pm_new[i];
                mem[stage_reg] <= dec_new;
                sel_reg        <= sel_next;
                stage_reg      <= stage_reg + PTR_W'(1);
            end
            if (state_reg == ST_TB) begin
                if (ptr_reg == '0) begin
                    ptr_reg     <= LAST_STAGE;
                    stage_reg   <= '0;
                    pm_reg[S00] <= '0;
                    pm_reg[S01] <= PM_START;
                    pm_reg[S10] <= PM_START;
                    pm_reg[S11] <= PM_START;
                end else begin
                    ptr_reg <= ptr_reg - PTR_W'(1);
                end
            end
        end
    end

    assign o_select_node   = sel_reg;
    assign o_bck_prv_st_00 = {1'b0, rd_data_reg[S00]};
    assign o_bck_prv_st_01 = {1'b1, rd_data_reg[S01]};
    assign o_bck_prv_st_10 = {1'b0, rd_data_reg[S10]};
    assign o_bck_prv_st_11 = {1'b1, rd_data_reg[S11]};

endmodule

// File: tb/tb_acs_survivor_mem.sv
// Directed bench for acs_survivor_mem with a behavioural Viterbi model feeding a scoreboard.
module tb_acs_survivor_mem;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_valid;
    logic [1:0] i_symbol;
    logic       o_ready;
    logic [1:0] o_select_node;
    logic       o_en_traceback;
    logic [1:0] o_bck_prv_st_00, o_bck_prv_st_01, o_bck_prv_st_10, o_bck_prv_st_11;

    acs_survivor_mem dut (
        .clk             (clk),
        .rst             (rst),
        .i_valid         (i_valid),
        .i_symbol        (i_symbol),
        .o_ready         (o_ready),
        .o_select_node   (o_select_node),
        .o_en_traceback  (o_en_traceback),
        .o_bck_prv_st_00 (o_bck_prv_st_00),
        .o_bck_prv_st_01 (o_bck_prv_st_01),
        .o_bck_prv_st_10 (o_bck_prv_st_10),
        .o_bck_prv_st_11 (o_bck_prv_st_11)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [1:0] syms  [8];
    logic [1:0] chain [8];
    logic [7:0] sel_q [$];
    logic [7:0] prv_q [$];
    int         m_pm  [4];
    logic [3:0] m_dec [8];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [1:0] pick(input logic [7:0] v, input logic [1:0] idx);
        return v[2*idx +: 2];
    endfunction

    function automatic logic [7:0] prv_bus();
        return {o_bck_prv_st_11, o_bck_prv_st_10, o_bck_prv_st_01, o_bck_prv_st_00};
    endfunction

    // Straight trellis walk; expected select/pm and playback words go to the scoreboard.
    task automatic model_and_push();
        int npm [4];
        int cand [2];
        int best;
        logic [7:0] w;
        m_pm = '{0, 15, 15, 15};
        for (int t = 0; t < 8; t++) begin
            for (int s = 0; s < 4; s++) begin
                logic u, a;
                u = s[1];
                a = s[0];
                for (int j = 0; j < 2; j++) begin
                    logic c0, c1;
                    c0 = u ^ a ^ j[0];
                    c1 = u ^ j[0];
                    cand[j] = m_pm[{a, j[0]}] + int'(syms[t][1] ^ c0) + int'(syms[t][0] ^ c1);
                end
                m_dec[t][s] = (cand[1] < cand[0]);
                npm[s]      = (cand[1] < cand[0]) ? cand[1] : cand[0];
            end
            m_pm = npm;
        end
        best = 0;
        for (int s = 1; s < 4; s++) if (m_pm[s] < m_pm[best]) best = s;
        sel_q.push_back({m_pm[best][5:0], best[1:0]});
        for (int k = 0; k < 8; k++) begin
            for (int s = 0; s < 4; s++) w[2*s +: 2] = {s[0], m_dec[7-k][s]};
            prv_q.push_back(w);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {7'd0, o_ready}, 8'd1);
        check({tag, "_en"}, {7'd0, o_en_traceback}, 8'd0);
        check({tag, "_sel"}, {6'd0, o_select_node}, 8'd0);
        check({tag, "_prv"}, prv_bus(), 8'h88);
    endtask

    // Caller must be positioned at a negedge; the first symbol is driven right there.
    task automatic run_frame(input int rst_at, input bit chk_chain);
        logic [7:0] e;
        logic [1:0] cur, nxt;
        model_and_push();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            check("ready_acs", {7'd0, o_ready}, 8'd1);
            i_valid  = 1'b1;
            i_symbol = syms[i];
            @(posedge clk);
        end
        @(negedge clk);
        check("load_ready", {7'd0, o_ready}, 8'd0);
        check("load_en", {7'd0, o_en_traceback}, 8'd0);
        if (sel_q.size() == 0) begin
            check("sel_q_empty", 8'd1, 8'd0);
            e = '0;
        end else begin
            e = sel_q.pop_front();
        end
        check("select", {6'd0, o_select_node}, {6'd0, e[1:0]});
        check("pm_final", {2'd0, dut.pm_reg[e[1:0]]}, {2'd0, e[7:2]});
        $display("frame: select=%0d pm=%0d", o_select_node, dut.pm_reg[e[1:0]]);
        cur      = e[1:0];
        i_valid  = 1'b1;
        i_symbol = 2'($urandom_range(0, 3));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("tb_en", {7'd0, o_en_traceback}, 8'd1);
            check("tb_ready", {7'd0, o_ready}, 8'd0);
            if (prv_q.size() == 0) begin
                check("prv_q_empty", 8'd1, 8'd0);
                e = '0;
            end else begin
                e = prv_q.pop_front();
            end
            check("prv", prv_bus(), e);
            if (chk_chain) begin
                nxt = pick(prv_bus(), cur);
                check("chain", {6'd0, nxt}, {6'd0, chain[k]});
                cur = nxt;
            end
            i_symbol = 2'($urandom_range(0, 3));
            if (k == rst_at) begin
                #1 rst = 1'b1;
                #1;
                check("rst_async_en", {7'd0, o_en_traceback}, 8'd0);
                check("rst_async_ready", {7'd0, o_ready}, 8'd1);
                #1 rst = 1'b0;
                i_valid = 1'b0;
                sel_q.delete();
                prv_q.delete();
                return;
            end
        end
        @(negedge clk);
        check("post_en", {7'd0, o_en_traceback}, 8'd0);
        check("post_ready", {7'd0, o_ready}, 8'd1);
        i_valid = 1'b0;
    endtask

    task automatic load_zero();
        for (int i = 0; i < 8; i++) syms[i] = 2'b00;
    endtask

    task automatic load_encoded();
        syms = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00};
    endtask

    task automatic load_random();
        for (int i = 0; i < 8; i++) syms[i] = 2'($urandom_range(0, 3));
    endtask

    initial begin
        rst      = 1'b1;
        i_valid  = 1'b0;
        i_symbol = 2'b00;
        chain    = '{2'b00, 2'b00, 2'b01, 2'b11, 2'b10, 2'b01, 2'b10, 2'b00};
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        load_zero();
        run_frame(-1, 1'b0);

        load_encoded();
        run_frame(-1, 1'b1);

        load_encoded();
        syms[2] = 2'b10;
        run_frame(-1, 1'b1);

        load_zero();
        run_frame(-1, 1'b0);

        load_random();
        run_frame(3, 1'b0);
        @(negedge clk);
        check_reset_outputs("after_rst");

        load_encoded();
        run_frame(-1, 1'b1);

        load_random();
        run_frame(-1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
